frogger_game_ctrl: RTL and testbench
====================================

# frogger_game_ctrl

Game sequencer for the frogger datapath. It runs the IDLE/PLAY/DYING/WIN/GAME_OVER flow, generates the lane-advance tick whose period shrinks with level, and turns raw active-low buttons into single-cycle move pulses. It also tracks lives, level and score. It sits between the board switches and the frogger lane/frog logic, and is the only source of lane timing and frog movement commands.

## Interface
- TICK_BASE, 3125000: clk cycles per lane tick at level 0.
- TICK_STEP, 250000: cycles removed from the tick period per level; TICK_BASE > MAX_LEVEL*TICK_STEP is required.
- MAX_LEVEL, 7: highest level; level saturates here.
- LIVES, 3: lives loaded at game start (1..3).
- PAUSE_TICKS, 4: internal ticks spent in DYING/WIN before play resumes.

- clk  in  1  system clock
- reset  in  1  synchronous, active-low; low at a rising edge resets all state
- up, down, left, right  in  1 each  raw buttons, active-low, asynchronous to clk
- start  in  1  raw start button, active-low
- collision  in  1  datapath flag: frog overlaps a car this cycle
- at_top  in  1  datapath flag: frog is on row 0
- lane_tick  out  1  one-cycle pulse: advance lane pattern
- lane_reset  out  1  one-cycle pulse: lanes return to time state 0
- frog_reset  out  1  one-cycle pulse: frog to start row 7, column 8'b0001_0000
- move_up, move_down, move_left, move_right  out  1 each  one-cycle move commands
- lives  out  2  remaining lives
- level  out  3  current level
- score  out  8  crossings completed, saturating
- state  out  3  IDLE=0, PLAY=1, DYING=2, WIN=3, GAME_OVER=4
- game_over  out  1  high while state==GAME_OVER

## Operation
- **Reset values** (all outputs): state=IDLE, lives=0, level=0, score=0. All pulses, game_over, tick and pause counters are 0. Button synchronizer flops are 1.
- **Buttons:** each button goes through a 2-flop synchronizer plus a delayed copy. A press is the synced value going 1->0. Holding a button gives exactly one press.
- **Move priority:** at most one move pulse per cycle, priority up > down > left > right. Lower-priority presses in the same cycle are dropped, not queued. Moves are emitted only in PLAY.
- **Tick counter:** 28-bit counter, period P = TICK_BASE - level*TICK_STEP. It counts 0..P-1 and raises the internal tick when count==P-1, then wraps to 0. The counter runs in PLAY, DYING and WIN. lane_tick = internal tick && state==PLAY.
- **IDLE, GAME_OVER:** on a start press, load lives=LIVES, level=0, score=0, clear the tick counter, pulse lane_reset and frog_reset, and go to PLAY.
- **PLAY, collision (sampled high):**
  - lives decrements.
  - If the new value is 0, go to GAME_OVER.
  - Otherwise go to DYING and clear the pause counter.
- **PLAY, at_top without collision:**
  - score+1, saturating at 255.
  - level+1, saturating at MAX_LEVEL.
  - Go to WIN, clear the pause counter and the tick counter.
- **Simultaneous flags:** collision and at_top in the same cycle counts as a collision.
- **DYING:** the pause counter increments on each internal tick. When it reaches PAUSE_TICKS, pulse frog_reset and go to PLAY. Lanes keep their position.
- **WIN:** same pause. On exit, pulse frog_reset and lane_reset, and go to PLAY.
- **Ignored inputs:** collision and at_top are ignored outside PLAY. The start button is ignored in PLAY, DYING and WIN.

## Timing
- **Button to move pulse:** a button first sampled low at edge N gives a move pulse high during the cycle after edge N+2 (3-cycle latency), for one cycle.
- **Collision/win reaction:** collision or at_top sampled at edge N gives the state, lives, level and score updates visible after edge N. The next state is active from cycle N+1.
- **Start:**
  - start sampled low at edge N: lane_reset and frog_reset are high for one cycle after edge N+2.
  - state=PLAY from the same edge.
  - The first lane_tick arrives P cycles later.
- **Pause exit:** frog_reset and lane_reset pulse in the cycle after the exit edge. The next lane_tick arrives P cycles after the last pause tick.
- **Level change:** P is recomputed combinationally from level. It takes effect from the cleared counter on WIN entry.
- **Reset mid-game:** reset low at any edge forces reset values at that edge. Any pending pulse is suppressed and no partial decrement occurs.

## Test plan
Bench parameters: TICK_BASE=10, TICK_STEP=2, MAX_LEVEL=7, LIVES=3, PAUSE_TICKS=2.

1. **Start and tick:** release reset, then hold start low. Expect lane_reset and frog_reset pulsing once, state=1, lives=3, then lane_tick every 10 cycles.
2. **Held and simultaneous buttons:** hold up low for 50 cycles in PLAY; expect exactly one move_up, 3 cycles after up falls. Press up and left in the same cycle; expect move_up only.
3. **Collision path:**
   - Pulse collision in PLAY: expect lives=2, state=2, no lane_tick for 2 ticks (20 cycles), then frog_reset and state=1.
   - Repeat twice: after the third collision expect lives=0, state=4, game_over=1.
4. **Win path and saturation:**
   - Assert at_top: expect score=1, level=1, state=3. After 2 ticks of 8 cycles, expect frog_reset and lane_reset together, then lane_tick period 8.
   - Repeat 8 wins: level saturates at 7 (period 10-7*2=-4 is disallowed; use MAX_LEVEL=4 here, period stays 2).
5. **Simultaneous flags:** assert collision and at_top in the same cycle; expect lives-1, score unchanged, state=2.
6. **Reset mid-pause:** pull reset low during DYING; expect state=0, lives=0, score=0 and all pulses 0 on the next cycle. A later start press restarts with lives=3.

Source files
------------

// File: rtl/frogger_game_ctrl.sv
// frogger_game_ctrl
//   Game sequencer for the frogger datapath. Runs the IDLE/PLAY/DYING/WIN/
//   GAME_OVER flow, generates the lane-advance tick (period shrinks with
//   level), turns raw active-low buttons into single-cycle move pulses and
//   tracks lives, level and score.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | power-up, waiting for a start press
//   ST_PLAY      | game running, moves and lane ticks delivered
//   ST_DYING     | frog hit, pausing PAUSE_TICKS ticks, lanes hold position
//   ST_WIN       | frog reached row 0, pausing PAUSE_TICKS ticks
//   ST_GAME_OVER | out of lives, waiting for a start press
//
// Ports
//   clk                         system clock
//   reset                       synchronous active-low reset
//   up/down/left/right/start    raw active-low buttons (async to clk)
//   collision, at_top           datapath flags, honoured only in PLAY
//   lane_tick                   one-cycle lane advance pulse
//   lane_reset, frog_reset      one-cycle restart pulses
//   move_up/down/left/right     one-cycle move commands
//   lives, level, score         game counters
//   state                       current FSM state (IDLE=0 .. GAME_OVER=4)
//   game_over                   high while in GAME_OVER

module frogger_game_ctrl #(
    parameter int unsigned TICK_BASE   = 3125000,
    parameter int unsigned TICK_STEP   = 250000,
    parameter int unsigned MAX_LEVEL   = 7,
    parameter int unsigned LIVES       = 3,
    parameter int unsigned PAUSE_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       start,
    input  logic       collision,
    input  logic       at_top,
    output logic       lane_tick,
    output logic       lane_reset,
    output logic       frog_reset,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic [7:0] score,
    output logic [2:0] state,
    output logic       game_over
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_DYING     = 3'd2,
        ST_WIN       = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam logic [27:0] BASE_W      = 28'(TICK_BASE);
    localparam logic [27:0] STEP_W      = 28'(TICK_STEP);
    localparam logic [2:0]  MAX_LEVEL_W = 3'(MAX_LEVEL);
    localparam logic [1:0]  LIVES_W     = 2'(LIVES);
    localparam logic [7:0]  PAUSE_W     = 8'(PAUSE_TICKS);

    // Button bit order: {start, right, left, down, up}
    logic [4:0] sync1_q, sync2_q, dly_q;
    logic [4:0] press;

    state_t      state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [2:0]  level_q, level_d;
    logic [7:0]  score_q, score_d;
    logic [27:0] tick_cnt_q, tick_cnt_d;
    logic [7:0]  pause_q, pause_d;
    logic        lane_reset_q, lane_reset_d;
    logic        frog_reset_q, frog_reset_d;
    logic [3:0]  move_q, move_d;   // {right, left, down, up}

    logic [27:0] period;
    logic        running;
    logic        tick;

    // Falling edge of the synchronized level; holding gives one press.
    assign press = dly_q & ~sync2_q;

    assign period  = BASE_W - ({25'd0, level_q} * STEP_W);
    assign running = (state_q == ST_PLAY) || (state_q == ST_DYING) || (state_q == ST_WIN);
    assign tick    = running && (tick_cnt_q == period - 28'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q      <= 5'h1f;
            sync2_q      <= 5'h1f;
            dly_q        <= 5'h1f;
            state_q      <= ST_IDLE;
            lives_q      <= 2'd0;
            level_q      <= 3'd0;
            score_q      <= 8'd0;
            tick_cnt_q   <= 28'd0;
            pause_q      <= 8'd0;
            lane_reset_q <= 1'b0;
            frog_reset_q <= 1'b0;
            move_q       <= 4'd0;
        end else begin
            sync1_q      <= {start, right, left, down, up};
            sync2_q      <= sync1_q;
            dly_q        <= sync2_q;
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            score_q      <= score_d;
            tick_cnt_q   <= tick_cnt_d;
            pause_q      <= pause_d;
            lane_reset_q <= lane_reset_d;
            frog_reset_q <= frog_reset_d;
            move_q       <= move_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        level_d      = level_q;
        score_d      = score_q;
        pause_d      = pause_q;
        lane_reset_d = 1'b0;
        frog_reset_d = 1'b0;
        move_d       = 4'd0;
        if (running) begin
            tick_cnt_d = tick ? 28'd0 : tick_cnt_q + 28'd1;
        end else begin
            tick_cnt_d = tick_cnt_q;
        end

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (press[4]) begin
                    lives_d      = LIVES_W;
                    level_d      = 3'd0;
                    score_d      = 8'd0;
                    tick_cnt_d   = 28'd0;
                    lane_reset_d = 1'b1;
                    frog_reset_d = 1'b1;
                    state_d      = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (press[0])      move_d = 4'b0001;
                else if (press[1]) move_d = 4'b0010;
                else if (press[2]) move_d = 4'b0100;
                else if (press[3]) move_d = 4'b1000;

                // Collision wins over a simultaneous at_top.
                if (collision) begin
                    lives_d = lives_q - 2'd1;
                    pause_d = 8'd0;
                    state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_DYING;
                end else if (at_top) begin
                    if (score_q != 8'hff)      score_d = score_q + 8'd1;
                    if (level_q < MAX_LEVEL_W) level_d = level_q + 3'd1;
                    pause_d    = 8'd0;
                    // New level's period starts from a clean count.
                    tick_cnt_d = 28'd0;
                    state_d    = ST_WIN;
                end
            end
            ST_DYING, ST_WIN: begin
                if (tick) begin
                    pause_d = pause_q + 8'd1;
                    if (pause_q == PAUSE_W - 8'd1) begin
                        frog_reset_d = 1'b1;
                        lane_reset_d = (state_q == ST_WIN);
                        state_d      = ST_PLAY;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign lane_tick  = tick && (state_q == ST_PLAY);
    assign lane_reset = lane_reset_q;
    assign frog_reset = frog_reset_q;
    assign move_up    = move_q[0];
    assign move_down  = move_q[1];
    assign move_left  = move_q[2];
    assign move_right = move_q[3];
    assign lives      = lives_q;
    assign level      = level_q;
    assign score      = score_q;
    assign state      = state_q;
    assign game_over  = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Randomized bench for frogger_game_ctrl with a game-rule reference model.
module tb_frogger_game_ctrl;

    localparam int TB_BASE  = 10;
    localparam int TB_STEP  = 2;
    localparam int TB_MAXL  = 4;
    localparam int TB_LIVES = 3;
    localparam int TB_PAUSE = 2;
    localparam int N_CYC    = 9000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic b_up = 1'b1, b_down = 1'b1, b_left = 1'b1, b_right = 1'b1, b_start = 1'b1;
    logic collision = 1'b0, at_top = 1'b0;

    logic       lane_tick, lane_reset, frog_reset;
    logic       move_up, move_down, move_left, move_right;
    logic [1:0] lives;
    logic [2:0] level;
    logic [7:0] score;
    logic [2:0] state;
    logic       game_over;

    always #5 clk = ~clk;

    frogger_game_ctrl #(
        .TICK_BASE(TB_BASE), .TICK_STEP(TB_STEP), .MAX_LEVEL(TB_MAXL),
        .LIVES(TB_LIVES), .PAUSE_TICKS(TB_PAUSE)
    ) dut (
        .clk(clk), .reset(rst_n),
        .up(b_up), .down(b_down), .left(b_left), .right(b_right), .start(b_start),
        .collision(collision), .at_top(at_top),
        .lane_tick(lane_tick), .lane_reset(lane_reset), .frog_reset(frog_reset),
        .move_up(move_up), .move_down(move_down), .move_left(move_left), .move_right(move_right),
        .lives(lives), .level(level), .score(score), .state(state), .game_over(game_over)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cur_cyc  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cur_cyc, obs, exp);
        else
            n_pass++;
    endtask

    // Reference model: game rules in plain integers.
    // samp[k] = button levels seen at edge k ({start,right,left,down,up}).
    logic [4:0] samp [0:N_CYC+15];
    int m_st, m_lives, m_level, m_score, m_phase, m_pause;
    bit m_lr, m_fr;
    bit [3:0] m_mv;

    task automatic model_step(input int k);
        logic [4:0] pr;
        int per;
        bit tk;
        m_lr = 0; m_fr = 0; m_mv = 4'd0;
        if (!rst_n) begin
            samp[k] = 5'h1f; samp[k-1] = 5'h1f; samp[k-2] = 5'h1f;
            m_st = 0; m_lives = 0; m_level = 0; m_score = 0; m_phase = 0; m_pause = 0;
            return;
        end
        samp[k] = {b_start, b_right, b_left, b_down, b_up};
        // Press is recognised 2 edges after the button is first seen low.
        pr  = ~samp[k-2] & samp[k-3];
        per = TB_BASE - m_level * TB_STEP;
        tk  = (m_st >= 1 && m_st <= 3) && (m_phase == per - 1);
        if (m_st >= 1 && m_st <= 3) m_phase = tk ? 0 : m_phase + 1;
        case (m_st)
            0, 4: if (pr[4]) begin
                m_lives = TB_LIVES; m_level = 0; m_score = 0; m_phase = 0;
                m_lr = 1; m_fr = 1; m_st = 1;
            end
            1: begin
                if (pr[0])      m_mv = 4'b0001;
                else if (pr[1]) m_mv = 4'b0010;
                else if (pr[2]) m_mv = 4'b0100;
                else if (pr[3]) m_mv = 4'b1000;
                if (collision) begin
                    m_lives = m_lives - 1;
                    m_st = (m_lives == 0) ? 4 : 2;
                    m_pause = 0;
                end else if (at_top) begin
                    if (m_score < 255) m_score = m_score + 1;
                    if (m_level < TB_MAXL) m_level = m_level + 1;
                    m_st = 3; m_pause = 0; m_phase = 0;
                end
            end
            2, 3: if (tk) begin
                m_pause = m_pause + 1;
                if (m_pause == TB_PAUSE) begin
                    m_fr = 1; m_lr = (m_st == 3); m_st = 1;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_all();
        bit exp_tick;
        exp_tick = (m_st == 1) && (m_phase == TB_BASE - m_level * TB_STEP - 1);
        check("state",      32'(state),      32'(m_st));
        check("lives",      32'(lives),      32'(m_lives));
        check("level",      32'(level),      32'(m_level));
        check("score",      32'(score),      32'(m_score));
        check("lane_tick",  32'(lane_tick),  32'(exp_tick));
        check("lane_reset", 32'(lane_reset), 32'(m_lr));
        check("frog_reset", 32'(frog_reset), 32'(m_fr));
        check("move_up",    32'(move_up),    32'(m_mv[0]));
        check("move_down",  32'(move_down),  32'(m_mv[1]));
        check("move_left",  32'(move_left),  32'(m_mv[2]));
        check("move_right", 32'(move_right), 32'(m_mv[3]));
        check("game_over",  32'(game_over),  32'(m_st == 4));
    endtask

    initial begin
        int p_col, p_top;
        for (int i = 0; i < N_CYC + 16; i++) samp[i] = 5'h1f;
        m_st = 0; m_lives = 0; m_level = 0; m_score = 0; m_phase = 0; m_pause = 0;
        m_lr = 0; m_fr = 0; m_mv = 4'd0;
        @(negedge clk);
        for (int c = 0; c < N_CYC; c++) begin
            cur_cyc = c;
            // Phase 0: mixed; phase 1: wins only (level/score saturation); phase 2: busy flags.
            if (c < 2000)      begin p_col = 60; p_top = 60; end
            else if (c < 7000) begin p_col = 0;  p_top = 3;  end
            else               begin p_col = 8;  p_top = 8;  end
            if (c < 3)
                rst_n = 1'b0;
            else if (c >= 2000 && c < 7000)
                rst_n = 1'b1;
            else
                rst_n = ($urandom_range(0, 699) != 0);
            if ($urandom_range(0, 5) == 0) b_up    = ~b_up;
            if ($urandom_range(0, 5) == 0) b_down  = ~b_down;
            if ($urandom_range(0, 5) == 0) b_left  = ~b_left;
            if ($urandom_range(0, 5) == 0) b_right = ~b_right;
            if ($urandom_range(0, 5) == 0) b_start = ~b_start;
            collision = (p_col != 0) && ($urandom_range(0, p_col - 1) == 0);
            at_top    = ($urandom_range(0, p_top - 1) == 0);
            @(posedge clk);
            model_step(c + 4);
            @(negedge clk);
            compare_all();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
